// File: rtl/out_arbiter.sv
// out_arbiter: time-shares one 4-bit output register among NREQ requesters with a minimum hold time.
// Define OUT_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module out_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              out_en,
  output logic [3:0]        out_d,
  output logic              busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, state_nx;
  logic [PW-1:0] sel, win;
  logic [CW-1:0] cnt;
`ifdef OUT_ARB_RR_EN
  logic [PW-1:0] ptr;
  int idx;
  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    win = '0;
    idx = 0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      idx = (int'(ptr) + o) % NREQ;
      if (req[idx]) win = PW'(idx);
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (state == LOAD) ptr <= int'(sel) == NREQ - 1 ? '0 : sel + 1'b1;
`else
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) win = PW'(i);
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (|req ? LOAD : IDLE) :
               state == LOAD ? (HOLD_CYCLES > 0 ? HOLD : IDLE) :
               (cnt == '0 ? IDLE : HOLD);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sel   <= '0;
      out_d <= 4'h0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && |req) begin
        sel   <= win;
        out_d <= data[4*int'(win) +: 4];
      end
      if (state == LOAD) cnt <= CW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
      else if (state == HOLD && cnt != '0) cnt <= cnt - 1'b1;
    end
  always_comb begin
    out_en = state == LOAD;
    busy   = state != IDLE;
    gnt    = out_en ? NREQ'(1) << sel : '0;
  end
endmodule

// File: tb/tb_out_arbiter.sv
// tb_out_arbiter: table vectors, directed corner cases and random traffic against a countdown model.
module tb_out_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] data = '0;
  logic [3:0] gnt_a, gnt_b, d_a, d_b;
  logic en_a, en_b, busy_a, busy_b;
  int errs = 0, checks = 0;
  int bl[2], mw[2], mptr[2];
  logic [3:0] md[2];
  bit ld[2];
  int hc[2] = '{8, 0};

  always #5 clk = ~clk;

  out_arbiter #(.NREQ(4), .HOLD_CYCLES(8)) u_a (.clk(clk), .reset(reset), .req(req), .data(data),
    .gnt(gnt_a), .out_en(en_a), .out_d(d_a), .busy(busy_a));
  out_arbiter #(.NREQ(4), .HOLD_CYCLES(0)) u_b (.clk(clk), .reset(reset), .req(req), .data(data),
    .gnt(gnt_b), .out_en(en_b), .out_d(d_b), .busy(busy_b));

  typedef struct {
    logic [3:0] r; logic [15:0] dt; logic [3:0] g; logic e; logic [3:0] d; logic b;
  } vec_t;
  vec_t tv[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(logic [3:0] r, int p);
    for (int o = 0; o < 4; o++) begin
`ifdef OUT_ARB_RR_EN
      int i = (p + o) % 4;
`else
      int i = o;
`endif
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      bl[k] = 0; mw[k] = 0; mptr[k] = 0; md[k] = 4'h0; ld[k] = 0;
    end
  endtask

  // Each write occupies the register for 1+H cycles; arbitration only when none remain.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      ld[k] = 0;
      if (bl[k] > 0) bl[k]--;
      else if (req != 0) begin
        mw[k] = pick(req, mptr[k]);
        md[k] = data[4*mw[k] +: 4];
        bl[k] = hc[k] + 1;
        ld[k] = 1;
        mptr[k] = (mw[k] + 1) % 4;
      end
    end
  endtask

  task automatic check_all();
    chk("gnt_a", gnt_a, ld[0] ? 1 << mw[0] : 0);
    chk("en_a", en_a, ld[0]);
    chk("d_a", d_a, md[0]);
    chk("busy_a", busy_a, bl[0] > 0);
    chk("gnt_b", gnt_b, ld[1] ? 1 << mw[1] : 0);
    chk("en_b", en_b, ld[1]);
    chk("d_b", d_b, md[1]);
    chk("busy_b", busy_b, bl[1] > 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    data = '0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    int t[5], w[5], n, waited;
    tv[0] = '{4'b0100, 16'h0A00, 4'b0100, 1'b1, 4'hA, 1'b1};
    for (int i = 1; i < 9; i++) tv[i] = '{4'b0000, 16'h0000, 4'b0000, 1'b0, 4'hA, 1'b1};
    tv[9] = '{4'b0000, 16'h0000, 4'b0000, 1'b0, 4'hA, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req = tv[i].r;
      data = tv[i].dt;
      tick();
      chk($sformatf("tv%0d_gnt", i), gnt_a, tv[i].g);
      chk($sformatf("tv%0d_en", i), en_a, tv[i].e);
      chk($sformatf("tv%0d_d", i), d_a, tv[i].d);
      chk($sformatf("tv%0d_busy", i), busy_a, tv[i].b);
    end

    do_reset();
    req = 4'b1111;
    data = 16'h4321;
    n = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (en_a && n < 5) begin
        t[n] = c;
        w[n] = gnt_a[0] ? 0 : gnt_a[1] ? 1 : gnt_a[2] ? 2 : gnt_a[3] ? 3 : -1;
        n++;
      end
    end
    chk("grant_count", n, 5);
    for (int i = 0; i < n; i++) begin
`ifdef OUT_ARB_RR_EN
      chk($sformatf("order%0d", i), w[i], i % 4);
`else
      chk($sformatf("order%0d", i), w[i], 0);
`endif
      if (i > 0) chk($sformatf("spacing%0d", i), t[i] - t[i-1], 10);
    end

    do_reset();
    req = 4'b0010;
    data = 16'h00B0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("h0_toggle%0d", i), en_b, i % 2 == 0);
      chk($sformatf("h0_busy%0d", i), busy_b, en_b);
    end

    do_reset();
    req = 4'b0001;
    data = 16'h0003;
    tick();
    req = '0;
    tick();
    tick();
    req = 4'b0100;
    data = 16'h0C00;
    waited = 0;
    while (waited < 30) begin
      tick();
      waited++;
      if (gnt_a[2]) break;
    end
    chk("hold_wait", waited, 8);
    chk("hold_d", d_a, 4'hC);
    req = '0;
    tick();

    do_reset();
    req = 4'b0001;
    data = 16'h0005;
    tick();
    chk("mid_load_d", d_a, 4'h5);
    req = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_en", en_a, 0);
    chk("rst_gnt", gnt_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_d", d_a, 0);
    chk("rst_b_busy", busy_b, 0);
    model_reset();
    req = 4'b1000;
    data = 16'h7000;
    #1 reset = 1'b0;
    tick();
    chk("post_rst_gnt", gnt_a, 4'b1000);
    chk("post_rst_d", d_a, 4'h7);
    req = '0;
    tick();

    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = 4'($urandom);
      data = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/out_arbiter.md
# out_arbiter

- Shares the single 4-bit output register (LED port) between `NREQ` requesters.
- Round-robin arbitration; the winner's nibble is latched and driven onto the register's `D` with a one-cycle `enable` pulse.
- A minimum display time then elapses before the next write, so every written value is visible for a bounded interval.
- Sits between the requesting datapath blocks and the output flip-flop bank, and is the only driver of that bank's `enable`.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `HOLD_CYCLES`, default 8: minimum cycles a written value is held before the next grant, 0..255.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  NREQ  per-requester write request, level; held until matching `gnt`.
- `data`  in  4*NREQ  nibble for requester i in bits [4i+3:4i]; stable while `req[i]` is high.
- `gnt`  out  NREQ  one-hot, one-cycle pulse acknowledging the accepted request.
- `out_en`  out  1  enable to the output register, one-cycle pulse.
- `out_d`  out  4  nibble to the output register's `D`.
- `busy`  out  1  high in LOAD and HOLD.

## Operation

- States: IDLE, LOAD, HOLD.
- **IDLE:**
  - At a clock edge with `req != 0`, select a winner `w` by round-robin from pointer `ptr`: the first set `req` bit at index `ptr`, `ptr+1`, …, wrapping modulo NREQ.
  - At that edge, latch `data[w]` into the `out_d` register and `w` into the `sel` register; go to LOAD.
  - With `req == 0`, stay in IDLE.
- **LOAD** (exactly one cycle):
  - `out_en` = 1 and `gnt[w]` = 1; `out_d` holds the latched nibble.
  - At exit, `ptr` ← (w+1) mod NREQ.
  - Next state is HOLD if HOLD_CYCLES > 0, otherwise IDLE.
  - The hold counter loads HOLD_CYCLES−1.
- **HOLD:**
  - Counter decrements each cycle; go to IDLE on the edge where the counter is 0.
  - Requests are ignored (not granted, not lost); they remain pending as levels.
- Once a winner is latched, the transfer completes even if `req[w]` drops before `gnt`.
- Requester behaviour after `gnt`: deassert `req` by the following edge or it is treated as a new request.
- `out_d` keeps its last value outside LOAD; only `out_en` qualifies it.
- Counter width: `$clog2(HOLD_CYCLES+1)`, minimum 1 bit.
- `ptr` is `$clog2(NREQ)` bits and wraps modulo NREQ for non-power-of-2 NREQ.

## Timing

- Reset values (asynchronous, immediate): state = IDLE, `ptr` = 0, counter = 0, `gnt` = 0, `out_en` = 0, `out_d` = 4'b0000, `busy` = 0.
- Latency:
  - `req` sampled at edge k (in IDLE).
  - `gnt`/`out_en` high during cycle k→k+1.
  - Output register Q updates at edge k+1.
- Back-to-back throughput: one write per HOLD_CYCLES+2 cycles. With HOLD_CYCLES = 0, one write per 2 cycles.
- `busy` rises the cycle after the arbitration edge and falls on entry to IDLE.
- Reset mid-LOAD or mid-HOLD:
  - Abort immediately; no `gnt` is issued for the aborted transfer.
  - Requester must re-present its request.
- All outputs are registered; no combinational path from `req`/`data` to any output.

## Configuration

- `OUT_ARB_RR_EN` defined: round-robin selection with rotating `ptr` as described.
- `OUT_ARB_RR_EN` undefined: fixed priority, lowest index wins. The `ptr` register is removed; timing and handshake are unchanged.

## Test plan

- Reset, then `req` = 4'b0100 with `data[11:8]` = 4'hA:
  - `gnt` = 4'b0100 and `out_en` = 1 for exactly one cycle, one cycle after sampling.
  - `out_d` = 4'hA; `busy` high for 1+8 cycles.
- All four `req` held high with distinct nibbles 1,2,3,4, RR enabled:
  - Grant order 0,1,2,3,0.
  - Consecutive `out_en` pulses exactly 10 cycles apart.
- Same stimulus with `OUT_ARB_RR_EN` undefined: requester 0 granted every time while `req[0]` is held.
- HOLD_CYCLES = 0, `req[1]` held: `out_en` toggles every other cycle and `busy` = 1 only in LOAD.
- `req[2]` asserted during HOLD: no `gnt` until the HOLD count expires, then granted on the next arbitration edge.
- Assert `reset` during LOAD with `out_d` = 4'h5 latched:
  - `out_en`, `gnt` and `busy` go 0 at once and `out_d` = 0.
  - After release, a pending `req[3]` is granted with `ptr` = 0 semantics.
